multi_evt_counter: RTL and testbench
====================================

Name: multi_evt_counter

Overview:
- Multi-channel successor to the single event counter. Holds NUM_CH independent modulo-MAX_COUNT counters.
- Each channel adds up/down direction, wrap or saturate mode, synchronous clear-to-offset, parallel load, a terminal-count pulse and a sticky saturation flag.
- A global snapshot port captures all channels coherently in one cycle, so downstream logic (time-of-flight, echo timing) can read consistent counts.

Parameters:
- NUM_CH, 4: number of independent counter channels (>=1).
- MAX_COUNT, 2147483647: modulus. Count range is 0..MAX_COUNT-1. Must be >=2.
- SATURATE, 0: 0 = wrap at range ends; 1 = hold at range ends.
- W, $clog2(MAX_COUNT): derived count width, localparam.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- evt_in  input  NUM_CH  per-channel count event, one step per cycle high.
- dir_in  input  NUM_CH  per-channel direction: 1 = up, 0 = down.
- clr_in  input  NUM_CH  per-channel synchronous clear to that channel's offset.
- load_in  input  NUM_CH  per-channel synchronous parallel load.
- load_val_in  input  NUM_CH*W  load values; channel i occupies bits [i*W +: W].
- default_offset  input  NUM_CH*W  clear values, same packing as load_val_in.
- snap_in  input  1  capture all counts.
- count_out  output  NUM_CH*W  live counts, same packing.
- tc_out  output  NUM_CH  one-cycle terminal-count (wrap or saturate-hit) pulse.
- sat_out  output  NUM_CH  sticky saturation flag, meaningful only when SATURATE=1.
- snap_out  output  NUM_CH*W  captured counts.
- snap_valid_out  output  1  one-cycle pulse when snap_out is updated.

Behaviour:
- Async reset (rst_in high, immediate, no clock needed): count_out=0, tc_out=0, sat_out=0, snap_out=0, snap_valid_out=0. Reset loads 0, not the offset. Software issues clr_in after reset to apply offsets.
- Per-channel priority each cycle: clr_in > load_in > evt_in > hold.
- clr: count <= default_offset[i], sat cleared, tc=0.
- load: count <= load_val[i], sat cleared, tc=0.
- Offset or load value >= MAX_COUNT is reduced to MAX_COUNT-1; the count never leaves the range.
- evt, up, SATURATE=0: MAX_COUNT-1 -> 0, tc pulses. Otherwise +1.
- evt, down, SATURATE=0: 0 -> MAX_COUNT-1, tc pulses. Otherwise -1.
- evt, up, SATURATE=1: at MAX_COUNT-1 the count holds; tc pulses and sat sets.
- evt, down, SATURATE=1: at 0 the count holds; tc pulses and sat sets.
- In saturate mode, tc pulses on every blocked event, not only the first.
- Latency: count_out reflects an event one cycle after the evt_in edge. tc_out is registered and asserts in the same cycle as the wrapped or held count appears.
- tc_out is low in every cycle not caused by a wrap or saturate event.
- Channels are fully independent; simultaneous events on all channels are legal.
- Snapshot: when snap_in is high at an edge, snap_out <= the count_out value present before that edge, for all channels. An evt in the same cycle is not included in the snapshot. snap_valid_out=1 for exactly the following cycle.
- snap_in held high: snap_out re-captures every cycle and snap_valid_out stays high.
- snap_out holds its value between captures.
- Reset mid-operation clears everything immediately, including a pending snapshot. No pulse is emitted after reset release.
- Arithmetic is done in W+1 bits to detect range ends without overflow. Outputs are exactly W bits.

Test Plan:
- Reset and offset: MAX_COUNT=16, NUM_CH=2. Assert rst_in mid-cycle -> all outputs 0 before the next edge. Release, clr_in=2'b11 with offsets 5 and 9 -> count_out ch0=5, ch1=9.
- Up wrap: ch0 loaded to 14, dir=1, 3 events -> counts 15, 0, 1. tc_out[0] high only in the cycle count=0.
- Down wrap: ch1 at 1, dir=0, 2 events -> 0 then 15. tc_out[1] pulses with 15.
- Saturate: SATURATE=1, ch0 at 14, 3 up-events -> 15, 15, 15. tc pulses on the 2nd and 3rd events. sat_out[0]=1 until load_in, then 0.
- Priority: clr_in, load_in and evt_in all high on ch0 in the same cycle -> count = offset, tc=0. Then load_in+evt_in with load_val=7 -> count=7.
- Snapshot coherence: ch0=3, ch1=8. Pulse snap_in together with evt on both channels -> snap_out={8,3}, snap_valid_out high 1 cycle, count_out={9,4}.

Source files
------------

// File: rtl/multi_evt_counter.sv
// multi_evt_counter: NUM_CH independent modulo-MAX_COUNT up/down counters
// with wrap/saturate, clear, load, terminal-count and coherent snapshot.
module multi_evt_counter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_COUNT = 2147483647,
    parameter bit SATURATE  = 1'b0,
    localparam int W        = $clog2(MAX_COUNT)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_CH-1:0]   evt_in,
    input  logic [NUM_CH-1:0]   dir_in,
    input  logic [NUM_CH-1:0]   clr_in,
    input  logic [NUM_CH-1:0]   load_in,
    input  logic [NUM_CH*W-1:0] load_val_in,
    input  logic [NUM_CH*W-1:0] default_offset,
    input  logic                snap_in,
    output logic [NUM_CH*W-1:0] count_out,
    output logic [NUM_CH-1:0]   tc_out,
    output logic [NUM_CH-1:0]   sat_out,
    output logic [NUM_CH*W-1:0] snap_out,
    output logic                snap_valid_out
);

    // Highest legal count, one bit wider so range ends never overflow.
    localparam logic [W:0] TOP = (W+1)'(MAX_COUNT - 1);

    logic [NUM_CH*W-1:0] count_q, count_d;
    logic [NUM_CH-1:0]   tc_q, tc_d;
    logic [NUM_CH-1:0]   sat_q, sat_d;
    logic [NUM_CH*W-1:0] snap_q, snap_d;
    logic                snap_valid_q, snap_valid_d;

    // Out-of-range offsets/load values are pulled down to the top count.
    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        if ({1'b0, v} > TOP) return TOP[W-1:0];
        return v;
    endfunction

    // Per-channel next state: clear > load > event > hold.
    always_comb begin
        logic [W:0] cur;
        count_d = count_q;
        tc_d    = '0;
        sat_d   = sat_q;
        cur     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur = {1'b0, count_q[i*W +: W]};
            if (clr_in[i]) begin
                count_d[i*W +: W] = clamp(default_offset[i*W +: W]);
                sat_d[i] = 1'b0;
            end else if (load_in[i]) begin
                count_d[i*W +: W] = clamp(load_val_in[i*W +: W]);
                sat_d[i] = 1'b0;
            end else if (evt_in[i]) begin
                if (dir_in[i]) begin
                    if (cur == TOP) begin
                        tc_d[i] = 1'b1;
                        if (SATURATE) sat_d[i] = 1'b1;
                        else count_d[i*W +: W] = '0;
                    end else begin
                        count_d[i*W +: W] = W'(cur + (W+1)'(1));
                    end
                end else begin
                    if (cur == '0) begin
                        tc_d[i] = 1'b1;
                        if (SATURATE) sat_d[i] = 1'b1;
                        else count_d[i*W +: W] = TOP[W-1:0];
                    end else begin
                        count_d[i*W +: W] = W'(cur - (W+1)'(1));
                    end
                end
            end
        end
    end

    // Snapshot takes the pre-edge counts of every channel at once.
    always_comb begin
        snap_d       = snap_in ? count_q : snap_q;
        snap_valid_d = snap_in;
    end

    // State registers; reset yields zero counts, not the offsets.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q      <= '0;
            tc_q         <= '0;
            sat_q        <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            tc_q         <= tc_d;
            sat_q        <= sat_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign count_out      = count_q;
    assign tc_out         = tc_q;
    assign sat_out        = sat_q;
    assign snap_out       = snap_q;
    assign snap_valid_out = snap_valid_q;

endmodule

// File: tb/tb_multi_evt_counter.sv
// tb_multi_evt_counter: wrap and saturate instances driven in lockstep,
// expected responses queued by stimulus and checked by a monitor.
module tb_multi_evt_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] evt, dir, clr, load;
    logic [7:0] lv, off;
    logic       snap;

    logic [7:0] c0, c1, s0, s1;
    logic [1:0] tc0, tc1, sat0, sat1;
    logic       sv0, sv1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      nm;
        logic [7:0] c0;
        logic [1:0] t0;
        logic [7:0] c1;
        logic [1:0] t1;
        logic [1:0] a1;
        logic [7:0] sn;
        logic       sv;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    multi_evt_counter #(.NUM_CH(2), .MAX_COUNT(16), .SATURATE(1'b0)) u_wrap (
        .clk_in(clk), .rst_in(rst), .evt_in(evt), .dir_in(dir),
        .clr_in(clr), .load_in(load), .load_val_in(lv),
        .default_offset(off), .snap_in(snap), .count_out(c0),
        .tc_out(tc0), .sat_out(sat0), .snap_out(s0),
        .snap_valid_out(sv0)
    );

    multi_evt_counter #(.NUM_CH(2), .MAX_COUNT(16), .SATURATE(1'b1)) u_sat (
        .clk_in(clk), .rst_in(rst), .evt_in(evt), .dir_in(dir),
        .clr_in(clr), .load_in(load), .load_val_in(lv),
        .default_offset(off), .snap_in(snap), .count_out(c1),
        .tc_out(tc1), .sat_out(sat1), .snap_out(s1),
        .snap_valid_out(sv1)
    );

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input string nm,
                        input logic [1:0] e, input logic [1:0] d,
                        input logic [1:0] c, input logic [1:0] l,
                        input logic [7:0] v, input logic s,
                        input logic [7:0] xc0, input logic [1:0] xt0,
                        input logic [7:0] xc1, input logic [1:0] xt1,
                        input logic [1:0] xa1, input logic [7:0] xsn,
                        input logic xsv);
        exp_t x;
        @(negedge clk);
        evt = e; dir = d; clr = c; load = l; lv = v; snap = s;
        x.nm = nm; x.c0 = xc0; x.t0 = xt0; x.c1 = xc1; x.t1 = xt1;
        x.a1 = xa1; x.sn = xsn; x.sv = xsv;
        q.push_back(x);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_cnt0"}, c0, 8'h00);
        chk({nm, "_cnt1"}, c1, 8'h00);
        chk({nm, "_tc0"}, {6'd0, tc0}, 8'h00);
        chk({nm, "_tc1"}, {6'd0, tc1}, 8'h00);
        chk({nm, "_sat0"}, {6'd0, sat0}, 8'h00);
        chk({nm, "_sat1"}, {6'd0, sat1}, 8'h00);
        chk({nm, "_snap0"}, s0, 8'h00);
        chk({nm, "_snap1"}, s1, 8'h00);
        chk({nm, "_sv0"}, {7'd0, sv0}, 8'h00);
        chk({nm, "_sv1"}, {7'd0, sv1}, 8'h00);
    endtask

    // Monitor: one queued expectation per clock, checked after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, "_cnt_wrap"}, c0, e.c0);
            chk({e.nm, "_tc_wrap"}, {6'd0, tc0}, {6'd0, e.t0});
            chk({e.nm, "_sat_wrap"}, {6'd0, sat0}, 8'h00);
            chk({e.nm, "_cnt_sat"}, c1, e.c1);
            chk({e.nm, "_tc_sat"}, {6'd0, tc1}, {6'd0, e.t1});
            chk({e.nm, "_sat_sat"}, {6'd0, sat1}, {6'd0, e.a1});
            chk({e.nm, "_snap_wrap"}, s0, e.sn);
            chk({e.nm, "_snap_sat"}, s1, e.sn);
            chk({e.nm, "_sv_wrap"}, {7'd0, sv0}, {7'd0, e.sv});
            chk({e.nm, "_sv_sat"}, {7'd0, sv1}, {7'd0, e.sv});
        end
    end

    initial begin
        rst = 1'b1;
        evt = '0; dir = '0; clr = '0; load = '0; lv = '0; snap = 1'b0;
        off = 8'h95;
        #3;
        chk_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        //   name        evt    dir    clr    load   lv     snp
        //   wrap cnt/tc         sat cnt/tc/sat     snap   sv
        step("clr_offset", 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 0,
             8'h95, 2'b00, 8'h95, 2'b00, 2'b00, 8'h00, 0);
        step("load14", 2'b00, 2'b00, 2'b00, 2'b01, 8'h0E, 0,
             8'h9E, 2'b00, 8'h9E, 2'b00, 2'b00, 8'h00, 0);
        step("up_to15", 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 0,
             8'h9F, 2'b00, 8'h9F, 2'b00, 2'b00, 8'h00, 0);
        step("up_wrap", 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 0,
             8'h90, 2'b01, 8'h9F, 2'b01, 2'b01, 8'h00, 0);
        step("up_after", 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 0,
             8'h91, 2'b00, 8'h9F, 2'b01, 2'b01, 8'h00, 0);
        step("idle_sticky", 2'b00, 2'b01, 2'b00, 2'b00, 8'h00, 0,
             8'h91, 2'b00, 8'h9F, 2'b00, 2'b01, 8'h00, 0);
        step("load_ch1", 2'b00, 2'b00, 2'b00, 2'b10, 8'h10, 0,
             8'h11, 2'b00, 8'h1F, 2'b00, 2'b01, 8'h00, 0);
        step("down_to0", 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 0,
             8'h01, 2'b00, 8'h0F, 2'b00, 2'b01, 8'h00, 0);
        step("down_wrap", 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 0,
             8'hF1, 2'b10, 8'h0F, 2'b10, 2'b11, 8'h00, 0);
        step("load_clr_sat", 2'b00, 2'b00, 2'b00, 2'b01, 8'h07, 0,
             8'hF7, 2'b00, 8'h07, 2'b00, 2'b10, 8'h00, 0);
        step("prio_clr", 2'b01, 2'b01, 2'b01, 2'b01, 8'h03, 0,
             8'hF5, 2'b00, 8'h05, 2'b00, 2'b10, 8'h00, 0);
        step("prio_load", 2'b01, 2'b01, 2'b00, 2'b01, 8'h07, 0,
             8'hF7, 2'b00, 8'h07, 2'b00, 2'b10, 8'h00, 0);
        step("snap_setup", 2'b00, 2'b00, 2'b00, 2'b11, 8'h83, 0,
             8'h83, 2'b00, 8'h83, 2'b00, 2'b00, 8'h00, 0);
        step("snap_evt", 2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 1,
             8'h94, 2'b00, 8'h94, 2'b00, 2'b00, 8'h83, 1);
        step("snap_hold", 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0,
             8'h94, 2'b00, 8'h94, 2'b00, 2'b00, 8'h83, 0);
        step("snap_cont1", 2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 1,
             8'hA5, 2'b00, 8'hA5, 2'b00, 2'b00, 8'h94, 1);
        step("snap_cont2", 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 1,
             8'hA5, 2'b00, 8'hA5, 2'b00, 2'b00, 8'hA5, 1);
        step("snap_end", 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0,
             8'hA5, 2'b00, 8'hA5, 2'b00, 2'b00, 8'hA5, 0);

        // Mid-cycle reset while a snapshot pulse is showing.
        @(negedge clk);
        evt = 2'b11; dir = 2'b11; snap = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("reset_mid");
        @(negedge clk);
        evt = '0; dir = '0; snap = 1'b0;
        rst = 1'b0;
        step("post_reset", 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 0,
             8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
